// File: rtl/sine_pwm_pkg.sv
// Shared defaults and state encoding for the sine-driven PWM block.
// Holds the LEN/PERIOD defaults and the IDLE/RUN state type.
package sine_pkg;

  localparam int unsigned LEN_DEF    = 8;
  localparam int unsigned PERIOD_DEF = 200;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/sine_pwm_if.sv
// Valid/ready sample stream from the sine generator into the PWM block.
// The generator drives the master side; the PWM block takes the slave side.
interface sine_pwm_if
  import sine_pkg::*;
#(
  parameter int unsigned LEN = LEN_DEF
);

  logic [LEN-1:0] in_data;
  logic           in_valid;
  logic           in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/ltu.sv
// Unsigned less-than primitive shared across the codebase.
module ltu #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         lt_o
);

  assign lt_o = a_i < b_i;

endmodule

// File: rtl/sine_pwm_cnt.sv
// Modulo-PERIOD up-counter with enable; wrap_o flags the last count while enabled.
module sine_pwm_cnt #(
  parameter int unsigned W      = 9,
  parameter int unsigned PERIOD = 200
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] LAST = W'(PERIOD - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign wrap_o = en_i && (cnt_q == LAST);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sine_pwm.sv
// Sine-sample PWM modulator: one sample per PWM period, one-entry lookahead buffer,
// underrun flag when a period starts without a fresh sample.
module sine_pwm
  import sine_pkg::*;
#(
  parameter int unsigned LEN    = LEN_DEF,
  parameter int unsigned PERIOD = PERIOD_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  sine_pwm_if.slave   in_if,
  output logic        pwm_out,
  output logic        period_start,
  output logic        underrun
);

  // One extra bit so that PERIOD == 2**LEN is representable in the compare.
  localparam int unsigned     CW    = LEN + 1;
  localparam logic [CW-1:0]   PER_W = CW'(PERIOD);

  state_e         state_q, state_d;
  logic [LEN-1:0] active_q, active_d;
  logic [LEN-1:0] next_q, next_d;
  logic           next_valid_q, next_valid_d;
  logic           underrun_q, underrun_d;
  logic           alive_q;

  logic           run;
  logic           wrap;
  logic           xfer;
  logic           lt;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  active_ext;
  logic [CW-1:0]  duty;

  assign run = (state_q == RUN);

  sine_pwm_cnt #(
    .W      (CW),
    .PERIOD (PERIOD)
  ) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (run),
    .cnt_o  (cnt),
    .wrap_o (wrap)
  );

  // alive_q keeps in_ready low until the first edge after reset release.
  assign in_if.in_ready = alive_q && (!run || !next_valid_q || wrap);
  assign xfer           = in_if.in_valid && in_if.in_ready;

  assign active_ext = {1'b0, active_q};
  assign duty       = (active_ext >= PER_W) ? PER_W : active_ext;

  ltu #(
    .W (CW)
  ) u_cmp (
    .a_i  (cnt),
    .b_i  (duty),
    .lt_o (lt)
  );

  assign pwm_out      = run && lt;
  assign period_start = run && (cnt == '0);
  assign underrun     = underrun_q;

  always_comb begin
    state_d      = state_q;
    active_d     = active_q;
    next_d       = next_q;
    next_valid_d = next_valid_q;
    underrun_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d  = RUN;
          active_d = in_if.in_data;
        end
      end
      RUN: begin
        if (wrap) begin
          // At the wrap the buffer is consumed and may be refilled in the same cycle.
          underrun_d   = !next_valid_q;
          if (next_valid_q) begin
            active_d = next_q;
          end
          next_valid_d = xfer;
          if (xfer) begin
            next_d = in_if.in_data;
          end
        end else if (xfer) begin
          next_d       = in_if.in_data;
          next_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      active_q     <= '0;
      next_q       <= '0;
      next_valid_q <= 1'b0;
      underrun_q   <= 1'b0;
      alive_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      next_q       <= next_d;
      next_valid_q <= next_valid_d;
      underrun_q   <= underrun_d;
      alive_q      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sine_pwm.sv
// Directed bench for sine_pwm (LEN=8, PERIOD=200) with hand-computed high-times.
module tb_sine_pwm;

  localparam int unsigned LEN    = 8;
  localparam int unsigned PERIOD = 200;
  localparam int          NS     = 10;

  logic clk = 1'b0;
  logic rst_n;
  logic pwm_out, period_start, underrun;

  sine_pwm_if #(.LEN(LEN)) bus ();

  sine_pwm #(
    .LEN    (LEN),
    .PERIOD (PERIOD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_if        (bus),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Observes one full period starting at the current cycle (expected counter==0).
  task automatic measure(output int high, output int ps0, output int und0,
                         output int rdy_err, output int extra);
    high = 0; ps0 = 0; und0 = 0; rdy_err = 0; extra = 0;
    for (int i = 0; i < int'(PERIOD); i++) begin
      @(negedge clk);
      if (i == 0) begin
        ps0  = int'(period_start);
        und0 = int'(underrun);
      end else if (period_start || underrun) begin
        extra++;
      end
      high += int'(pwm_out);
      if (bus.in_ready != (i == int'(PERIOD) - 1)) rdy_err++;
      @(posedge clk);
      #1;
    end
  endtask

  int samples  [NS] = '{0, 1, 7, 16, 50, 120, 200, 255, 150, 1};
  int exp_high [NS] = '{0, 1, 7, 16, 50, 120, 200, 200, 150, 1};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int h, p, u, r, x, bad;
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    #1 rst_n = 1'b0;
    repeat (2) tick();
    check("rst_pwm",   int'(pwm_out),      0);
    check("rst_ps",    int'(period_start), 0);
    check("rst_und",   int'(underrun),     0);
    check("rst_ready", int'(bus.in_ready), 0);
    rst_n = 1'b1;
    tick();

    // Idle with no samples offered
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pwm_out || period_start || underrun || !bus.in_ready) bad++;
      @(posedge clk);
      #1;
    end
    check("idle_50", bad, 0);

    // Single sample of 100 accepted in IDLE, then starvation
    bus.in_data  = 8'd100;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    measure(h, p, u, r, x);
    check("one_p0_high", h, 100);
    check("one_p0_ps",   p, 1);
    check("one_p0_und",  u, 0);
    check("one_p0_extra", x, 0);
    for (int k = 1; k < 3; k++) begin
      measure(h, p, u, r, x);
      check("one_pk_high", h, 100);
      check("one_pk_ps",   p, 1);
      check("one_pk_und",  u, 1);
      check("one_pk_extra", x, 0);
    end

    // Continuous stream: one sample consumed per period, in order
    do_reset();
    fork
      begin
        int   k;
        int   guard;
        logic hs;
        k = 0;
        guard = 0;
        bus.in_data  = 8'(samples[0]);
        bus.in_valid = 1'b1;
        while (k < NS && guard < 5000) begin
          @(negedge clk);
          hs = bus.in_ready;
          @(posedge clk);
          #1;
          guard++;
          if (hs) begin
            k++;
            if (k < NS) bus.in_data = 8'(samples[k]);
          end
        end
        bus.in_valid = 1'b0;
        if (k < NS) check("feed_timeout", k, NS);
      end
      begin
        tick();
        for (int pp = 0; pp < NS; pp++) begin
          measure(h, p, u, r, x);
          check($sformatf("seq_high[%0d]", pp), h, exp_high[pp]);
          check($sformatf("seq_ps[%0d]", pp), p, 1);
          check($sformatf("seq_und[%0d]", pp), u, 0);
          check($sformatf("seq_extra[%0d]", pp), x, 0);
          if (pp >= 1 && pp <= NS - 2) check($sformatf("seq_ready[%0d]", pp), r, 0);
        end
        measure(h, p, u, r, x);
        check("seq_tail_high", h, 1);
        check("seq_tail_und",  u, 1);
      end
    join

    // Reset mid-period with a buffered sample
    do_reset();
    bus.in_data  = 8'd80;
    bus.in_valid = 1'b1;
    tick();
    bus.in_data  = 8'd30;
    tick();
    bus.in_valid = 1'b0;
    repeat (56) tick();
    check("pre_rst_pwm", int'(pwm_out), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_pwm",   int'(pwm_out),      0);
    check("mid_rst_ps",    int'(period_start), 0);
    check("mid_rst_und",   int'(underrun),     0);
    check("mid_rst_ready", int'(bus.in_ready), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", int'(bus.in_ready), 1);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (pwm_out || period_start || underrun || !bus.in_ready) bad++;
      @(posedge clk);
      #1;
    end
    check("post_rst_idle", bad, 0);
    bus.in_data  = 8'd10;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    measure(h, p, u, r, x);
    check("post_rst_p0_high", h, 10);
    check("post_rst_p0_ps",   p, 1);
    check("post_rst_p0_und",  u, 0);
    measure(h, p, u, r, x);
    check("post_rst_p1_high", h, 10);
    check("post_rst_p1_und",  u, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
